safety_monitor_multi: RTL and testbench

//   Parametrised N-channel current-safety monitor; successor of the fixed 4-instance safety check.

---
 rtl/safety_monitor_multi.sv | 164 ++++++++++++++++
 tb/tb_safety_monitor_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/safety_monitor_multi.sv
// N-channel over-current monitor: snapshots samples on strobe, scans channels through a
// 2-stage magnitude/compare pipeline, debounces failures and latches per-channel disables.
module safety_monitor_multi #(
   parameter int unsigned NUM_CHAN    = 4,
   parameter int unsigned DW          = 16,
   parameter int unsigned RATIO_SHIFT = 1,
   parameter int unsigned MARGIN      = 32'h0200,
   parameter int unsigned TRIP_COUNT  = 8,
   parameter logic [7:0]  STATUS_ADDR = 8'h0C
) (
   input  logic                   sysclk,
   input  logic                   reset,
   input  logic                   sample_stb,
   input  logic [NUM_CHAN*DW-1:0] cur_fb,
   input  logic [NUM_CHAN*DW-1:0] cur_cmd,
   input  logic                   reg_wen,
   input  logic [7:0]             reg_addr,
   input  logic [31:0]            reg_wdata,
   output logic [31:0]            reg_rdata,
   output logic [NUM_CHAN-1:0]    amp_disable,
   output logic                   fault_any
);

   localparam int unsigned IW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
   localparam int unsigned LW = DW + RATIO_SHIFT + 1;
   localparam int unsigned RN = (NUM_CHAN < 8) ? NUM_CHAN : 8;
   localparam logic [LW-1:0] MARGIN_L = LW'(MARGIN);
   localparam logic [7:0]    TRIP     = 8'(TRIP_COUNT);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SCAN  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]             state;
   logic [IW-1:0]          idx;
   logic                   drain_cnt;
   logic [NUM_CHAN*DW-1:0] snap_fb;
   logic [NUM_CHAN*DW-1:0] snap_cmd;
   logic                   s1_valid;
   logic [IW-1:0]          s1_ch;
   logic [DW-1:0]          s1_mag_fb;
   logic [DW-1:0]          s1_mag_cmd;
   logic [7:0]             cnt [NUM_CHAN];
   logic [7:0]             cnt_next [NUM_CHAN];
   logic [NUM_CHAN-1:0]    dis;
   logic [NUM_CHAN-1:0]    dis_next;
   logic                   overrun;
   logic                   overrun_next;
   logic                   fault;
   logic                   clear;
   logic [LW-1:0]          limit;
   logic                   fail;

   // Offset-binary to magnitude; the most-negative code maps to 1<<(DW-1) without wrapping.
   function automatic logic [DW-1:0] mag_of(input logic [DW-1:0] x);
      logic [DW-1:0] s;
      s = {~x[DW-1], x[DW-2:0]};
      return s[DW-1] ? (~s + DW'(1)) : s;
   endfunction

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         idx        <= '0;
         drain_cnt  <= 1'b0;
         snap_fb    <= '0;
         snap_cmd   <= '0;
         s1_valid   <= 1'b0;
         s1_ch      <= '0;
         s1_mag_fb  <= '0;
         s1_mag_cmd <= '0;
      end else begin
         s1_valid   <= (state == SCAN);
         s1_ch      <= idx;
         s1_mag_fb  <= mag_of(snap_fb[32'(idx)*DW +: DW]);
         s1_mag_cmd <= mag_of(snap_cmd[32'(idx)*DW +: DW]);
         case (state)
            IDLE: begin
               if (sample_stb) begin
                  snap_fb  <= cur_fb;
                  snap_cmd <= cur_cmd;
                  idx      <= '0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               idx <= IW'(idx + 1'b1);
               if (32'(idx) == NUM_CHAN - 1) begin
                  state     <= DRAIN;
                  drain_cnt <= 1'b0;
               end
            end
            DRAIN: begin
               drain_cnt <= 1'b1;
               if (drain_cnt) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign clear = reg_wen && (reg_addr == STATUS_ADDR);
   assign limit = (LW'(s1_mag_cmd) << RATIO_SHIFT) + MARGIN_L;
   assign fail  = LW'(s1_mag_fb) > limit;

   always_comb begin
      logic [7:0] nxt;
      cnt_next     = cnt;
      dis_next     = dis;
      overrun_next = overrun;
      nxt          = '0;
      if (clear && reg_wdata[31]) overrun_next = 1'b0;
      if (sample_stb && state != IDLE) overrun_next = 1'b1;
      for (int k = 0; k < NUM_CHAN; k++) begin
         if (clear && reg_wdata[k]) begin
            cnt_next[k] = '0;
            dis_next[k] = 1'b0;
         end
         if (s1_valid && 32'(s1_ch) == k) begin
            if (fail) begin
               nxt = (cnt[k] >= TRIP) ? TRIP : cnt[k] + 8'd1;
               // A trip overrides a clear landing in the same cycle.
               if (nxt == TRIP) begin
                  cnt_next[k] = TRIP;
                  dis_next[k] = 1'b1;
               end else if (!(clear && reg_wdata[k])) begin
                  cnt_next[k] = nxt;
               end
            end else begin
               cnt_next[k] = '0;
            end
         end
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NUM_CHAN; k++) cnt[k] <= '0;
         dis     <= '0;
         overrun <= 1'b0;
         fault   <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         dis     <= dis_next;
         overrun <= overrun_next;
         fault   <= |dis;
      end
   end

   always_comb begin
      reg_rdata = '0;
      if (reg_addr == STATUS_ADDR) begin
         reg_rdata[31] = overrun;
         for (int k = 0; k < RN; k++) begin
            reg_rdata[k]     = dis[k];
            reg_rdata[8 + k] = (cnt[k] != 8'd0);
         end
      end
   end

   assign amp_disable = dis;
   assign fault_any   = fault;

endmodule

// File: tb/tb_safety_monitor_multi.sv
// Directed plus randomized bench for safety_monitor_multi against a per-scan behavioural model.
module tb_safety_monitor_multi;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam logic [7:0] SA = 8'h0C;

   logic          sysclk = 1'b0;
   logic          reset  = 1'b1;
   logic          sample_stb = 1'b0;
   logic [N*DW-1:0] cur_fb  = {N{16'h8000}};
   logic [N*DW-1:0] cur_cmd = {N{16'h8000}};
   logic          reg_wen   = 1'b0;
   logic [7:0]    reg_addr  = SA;
   logic [31:0]   reg_wdata = '0;
   logic [31:0]   reg_rdata;
   logic [N-1:0]  amp_disable;
   logic          fault_any;

   int checks = 0;
   int errors = 0;
   int m_cnt [N];
   bit m_dis [N];
   bit m_ovr;

   safety_monitor_multi #(
      .NUM_CHAN(N), .DW(DW), .RATIO_SHIFT(1), .MARGIN(32'h200), .TRIP_COUNT(8), .STATUS_ADDR(SA)
   ) dut (
      .sysclk(sysclk), .reset(reset), .sample_stb(sample_stb), .cur_fb(cur_fb),
      .cur_cmd(cur_cmd), .reg_wen(reg_wen), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_rdata(reg_rdata), .amp_disable(amp_disable), .fault_any(fault_any)
   );

   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_amp();
      logic [31:0] r = '0;
      for (int k = 0; k < N; k++) r[k] = m_dis[k];
      return r;
   endfunction

   function automatic logic [31:0] exp_status();
      logic [31:0] r = '0;
      r[31] = m_ovr;
      for (int k = 0; k < N; k++) begin
         r[k]     = m_dis[k];
         r[8 + k] = (m_cnt[k] != 0);
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_cnt[k] = 0;
         m_dis[k] = 0;
      end
      m_ovr = 0;
   endtask

   // Whole-scan effect: signed currents, limit = 2*|cmd| + 0x200, strict compare.
   task automatic model_scan(input logic [N*DW-1:0] fb, input logic [N*DW-1:0] cmd,
                             output bit trip0);
      int f, c;
      trip0 = 0;
      for (int k = 0; k < N; k++) begin
         f = int'(fb[k*DW +: DW]) - 32768;
         c = int'(cmd[k*DW +: DW]) - 32768;
         if (f < 0) f = -f;
         if (c < 0) c = -c;
         if (f > 2 * c + 'h200) begin
            m_cnt[k] = (m_cnt[k] < 8) ? m_cnt[k] + 1 : 8;
            if (m_cnt[k] == 8) begin
               m_dis[k] = 1;
               if (k == 0) trip0 = 1;
            end
         end else begin
            m_cnt[k] = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_amp"}, 32'(amp_disable), exp_amp());
      check({tag, "_status"}, reg_rdata, exp_status());
      check({tag, "_fault"}, 32'(fault_any), 32'(|exp_amp()));
   endtask

   // mode 1: ch0 trip timing; mode 2: clear ch0 on its update cycle; mode 3: ch1/fault timing.
   task automatic do_scan(input logic [N*DW-1:0] fb, input logic [N*DW-1:0] cmd,
                          input int mode, input string tag);
      int used = 0;
      bit trip0;
      @(posedge sysclk); #1;
      cur_fb = fb; cur_cmd = cmd; sample_stb = 1'b1;
      @(posedge sysclk); #1;
      sample_stb = 1'b0;
      if (mode == 1) begin
         @(posedge sysclk); #1;
         check("trip_before_update", 32'(amp_disable[0]), 32'd0);
         @(posedge sysclk); #1;
         check("trip_at_update", 32'(amp_disable[0]), 32'd1);
         used = 2;
      end else if (mode == 2) begin
         @(posedge sysclk); #1;
         reg_wen = 1'b1; reg_wdata = 32'h1;
         @(posedge sysclk); #1;
         reg_wen = 1'b0;
         used = 2;
      end else if (mode == 3) begin
         repeat (3) begin
            @(posedge sysclk); #1;
         end
         check("ch1_trip", 32'(amp_disable[1]), 32'd1);
         check("fault_lag", 32'(fault_any), 32'd0);
         @(posedge sysclk); #1;
         check("fault_set", 32'(fault_any), 32'd1);
         used = 4;
      end
      repeat (N + 4 - used) begin
         @(posedge sysclk); #1;
      end
      model_scan(fb, cmd, trip0);
      if (mode == 2 && !trip0) begin
         m_cnt[0] = 0;
         m_dis[0] = 0;
      end
      check_all(tag);
   endtask

   task automatic write_clear(input logic [31:0] data, input string tag);
      @(posedge sysclk); #1;
      reg_wen = 1'b1; reg_wdata = data;
      @(posedge sysclk); #1;
      reg_wen = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (data[k]) begin
            m_cnt[k] = 0;
            m_dis[k] = 0;
         end
      end
      if (data[31]) m_ovr = 0;
      @(posedge sysclk); #1;
      check_all(tag);
   endtask

   logic [N*DW-1:0] mid, fb, cmd;

   initial begin
      mid = {N{16'h8000}};
      model_reset();
      #2 reset = 1'b0;
      #3 check_all("reset");
      @(posedge sysclk); #1 reset = 1'b1;

      // Reset mid-scan.
      fb = mid; fb[15:0] = 16'h0000;
      @(posedge sysclk); #1;
      cur_fb = fb; sample_stb = 1'b1;
      @(posedge sysclk); #1 sample_stb = 1'b0;
      @(posedge sysclk); #1 reset = 1'b0;
      repeat (3) @(posedge sysclk);
      #1 reset = 1'b1;
      model_reset();
      check_all("reset_midscan");
      do_scan(fb, mid, 0, "after_reset");
      write_clear(32'h1, "clr_after_reset");

      // Just under the limit: never trips.
      cmd = mid; cmd[15:0] = 16'h9000;
      fb = mid;  fb[15:0]  = 16'hA100;
      for (int i = 0; i < 8; i++) do_scan(fb, cmd, 0, "under_limit");
      fb[15:0] = 16'hA201;
      for (int i = 0; i < 7; i++) do_scan(fb, cmd, 0, "over_limit");
      do_scan(fb, cmd, 1, "over_limit_8th");
      write_clear(32'h1, "clr_ch0");

      // Debounce restart on a single passing scan.
      for (int i = 0; i < 7; i++) do_scan(fb, cmd, 0, "deb_a");
      do_scan(mid, mid, 0, "deb_pass");
      for (int i = 0; i < 7; i++) do_scan(fb, cmd, 0, "deb_b");
      write_clear(32'hF, "clr_deb");

      // Negative current on ch1.
      cmd = mid; cmd[31:16] = 16'h7000;
      fb = mid;  fb[31:16]  = 16'h0000;
      for (int i = 0; i < 7; i++) do_scan(fb, cmd, 0, "neg");
      do_scan(fb, cmd, 3, "neg_8th");
      write_clear(32'h2, "clr_ch1");

      // Clear landing on the same cycle as ch0's trip.
      cmd = mid; cmd[15:0] = 16'h9000;
      fb = mid;  fb[15:0]  = 16'hA201;
      for (int i = 0; i < 7; i++) do_scan(fb, cmd, 0, "race");
      do_scan(fb, cmd, 2, "race_8th");
      check("race_held", 32'(amp_disable[0]), 32'd1);
      write_clear(32'h1, "race_clr");

      // Overrun: second strobe one cycle later is ignored.
      @(posedge sysclk); #1;
      cur_fb = mid; cur_cmd = mid; sample_stb = 1'b1;
      @(posedge sysclk); #1;
      cur_fb = {N{16'h0000}};
      @(posedge sysclk); #1 sample_stb = 1'b0;
      repeat (N + 4) @(posedge sysclk);
      #1;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      m_ovr = 1;
      check_all("overrun");
      write_clear(32'h8000_0000, "overrun_clr");
      reg_addr = 8'h10;
      #1 check("other_addr", reg_rdata, 32'd0);
      reg_addr = SA;

      // Randomized scans with occasional clears.
      for (int i = 0; i < 60; i++) begin
         for (int k = 0; k < N; k++) begin
            cmd[k*DW +: DW] = 16'($urandom);
            case ($urandom_range(0, 3))
               0:       fb[k*DW +: DW] = cmd[k*DW +: DW];
               1:       fb[k*DW +: DW] = 16'h0000;
               2:       fb[k*DW +: DW] = 16'hFFFF;
               default: fb[k*DW +: DW] = 16'($urandom);
            endcase
         end
         do_scan(fb, cmd, 0, "rand");
         if ($urandom_range(0, 6) == 0) write_clear($urandom & 32'h8000_000F, "rand_clr");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
